alu_operand_loader: RTL and testbench
=====================================

// Module: alu_operand_loader
// PURPOSE
//  Upstream operand stage for the 16-bit ALU logic units (NOR/AND/OR...).
//  Assembles a byte-serial frame (opcode, A, B) from a narrow input bus.
//  Presents opcode and full-width A/B operands to the ALU with a valid/ready handshake.
//  Issued operands stay stable in output registers while the next frame loads.
// PARAMETERS
//  WIDTH  16  operand width; must be an integer multiple of BUS_W
//  BUS_W  8   input data bus width
//  OPW    3   opcode width (OPW <= BUS_W)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous reset, active low
//  in_valid   in   1      input beat valid
//  in_ready   out  1      loader can accept a beat
//  in_sof     in   1      start of frame; the beat carries the opcode
//  in_data    in   BUS_W  beat payload
//  out_valid  out  1      operands/opcode valid toward ALU
//  out_ready  in   1      ALU accepts operands
//  out_op     out  OPW    opcode of issued frame
//  out_a      out  WIDTH  operand A
//  out_b      out  WIDTH  operand B
//  err_frame  out  1      one-cycle pulse on a framing error
// BEHAVIOUR
//  Beat accepted = in_valid & in_ready. NB = WIDTH/BUS_W.
//  Frame = 1 opcode beat (in_sof=1, op=in_data[OPW-1:0]), then NB beats of A, then NB of B.
//  A and B arrive LSB byte first. in_sof is ignored on data beats unless stated below.
//  FSM states: IDLE, LOAD_A, LOAD_B, ISSUE. Beat counter is 0..NB-1 and clears on every state change.
//  IDLE: accepted beat with sof -> latch op, go to LOAD_A. Accepted beat without sof -> drop it, pulse err_frame.
//  LOAD_A/LOAD_B: accepted beat without sof -> write byte[cnt] of the shadow A/B register.
//   On cnt==NB-1: LOAD_A -> LOAD_B, LOAD_B -> ISSUE.
//  LOAD_A/LOAD_B, accepted beat with sof -> abort the partial frame and pulse err_frame.
//   That beat is taken as the new opcode; go to LOAD_A with cnt=0.
//  Entering ISSUE: copy shadow op/A/B into out_op/out_a/out_b. out_valid=1 on the next cycle.
//   Latency: 1 cycle after the last B beat is accepted.
//  ISSUE: out_valid=1; out_* held stable while out_ready=0.
//   On out_ready=1: go to IDLE, and out_valid=0 on the next cycle.
//  in_ready=1 in IDLE/LOAD_A/LOAD_B and 0 in ISSUE (registered, derived from state).
//  out_op/out_a/out_b keep their last issued values after the handshake and during the next load.
//  Shadow bytes not rewritten in an aborted frame are don't-care; they are never issued.
//  Idle cycles (in_valid=0) inside a frame are allowed, with no timeout; the result is identical.
//  Reset (rst_n=0 at a clk edge, any state, including mid-frame or in ISSUE):
//   state=IDLE, cnt=0, out_valid=0, out_op=0, out_a=0, out_b=0, err_frame=0, shadows=0.
//   Any partial frame is discarded. in_ready=1 from the first cycle after reset deasserts.
//  err_frame is registered and high for exactly one cycle per error event.
//  Minimum frame period is 1+2*NB+1 cycles (6 for defaults) with out_ready tied high.
// TESTING
//  1 Reset, then beats sof:03, AF, 68, 00, 00 back-to-back with out_ready=1 -> out_valid one cycle
//    after the 5th beat; out_op=3, out_a=16'h68AF, out_b=16'h0000; out_valid high for 1 cycle.
//  2 Frame op=1, A=FFFF, B=FF55 with out_ready=0 for 5 cycles -> out_valid, out_a and out_b stable and
//    in_ready=0 throughout; out_ready=1 -> out_valid=0 and in_ready=1 on the next cycle.
//  3 sof:02, 11, then sof:05, 00, 00, CC, CC -> err_frame pulses once on the 3rd beat;
//    then out_op=5, out_a=16'h0000, out_b=16'hCCCC.
//  4 In IDLE, beat 5A without sof -> err_frame 1 cycle; no out_valid; state stays IDLE.
//  5 rst_n=0 for 1 cycle during LOAD_B -> all outputs 0, in_ready=1; the next full frame issues correctly.
//  6 Frame from test 2 with in_valid toggled every cycle -> same out_* as back-to-back; no err_frame.

Source files
------------

// File: rtl/alu_operand_loader_if.sv
// rtl/alu_operand_loader_if.sv - beat input and operand output bundle of the ALU operand loader
interface alu_operand_loader_if #(
    parameter int WIDTH = 16,
    parameter int BUS_W = 8,
    parameter int OPW   = 3
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sof;
    logic [BUS_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OPW-1:0]   out_op;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic             err_frame;

    // Loader side.
    modport slave (
        input  in_valid, in_sof, in_data, out_ready,
        output in_ready, out_valid, out_op, out_a, out_b, err_frame
    );

    // Beat source / ALU side.
    modport master (
        output in_valid, in_sof, in_data, out_ready,
        input  in_ready, out_valid, out_op, out_a, out_b, err_frame
    );
endinterface

// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - assembles byte-serial opcode/A/B frames into full-width ALU operands
module alu_operand_loader #(
    parameter int WIDTH = 16,
    parameter int BUS_W = 8,
    parameter int OPW   = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    alu_operand_loader_if.slave       bus
);
    localparam int NB = WIDTH / BUS_W;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, ISSUE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [OPW-1:0]   shadow_op;
    logic [WIDTH-1:0] shadow_a;
    logic [WIDTH-1:0] shadow_b;
    logic [WIDTH-1:0] a_merge;
    logic [WIDTH-1:0] b_merge;
    logic [OPW-1:0]   out_op_q;
    logic [WIDTH-1:0] out_a_q;
    logic [WIDTH-1:0] out_b_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic             err_q;
    logic             accept;

    assign accept = bus.in_valid & in_ready_q;

    // Shadow registers with the current beat merged in, so the final B byte
    // can go straight to the output registers on the same edge.
    always_comb begin
        a_merge = shadow_a;
        b_merge = shadow_b;
        a_merge[int'(cnt) * BUS_W +: BUS_W] = bus.in_data;
        b_merge[int'(cnt) * BUS_W +: BUS_W] = bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            shadow_op   <= '0;
            shadow_a    <= '0;
            shadow_b    <= '0;
            out_op_q    <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.in_sof) begin
                            shadow_op <= bus.in_data[OPW-1:0];
                            state     <= LOAD_A;
                            cnt       <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD_A: begin
                    if (accept) begin
                        if (bus.in_sof) begin
                            shadow_op <= bus.in_data[OPW-1:0];
                            err_q     <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            shadow_a <= a_merge;
                            if (cnt == LAST) begin
                                state <= LOAD_B;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        if (bus.in_sof) begin
                            shadow_op <= bus.in_data[OPW-1:0];
                            err_q     <= 1'b1;
                            state     <= LOAD_A;
                            cnt       <= '0;
                        end else begin
                            shadow_b <= b_merge;
                            if (cnt == LAST) begin
                                out_op_q    <= shadow_op;
                                out_a_q     <= shadow_a;
                                out_b_q     <= b_merge;
                                out_valid_q <= 1'b1;
                                in_ready_q  <= 1'b0;
                                state       <= ISSUE;
                                cnt         <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_op    = out_op_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.err_frame = err_q;
endmodule

// File: tb/tb_alu_operand_loader.sv
// tb/tb_alu_operand_loader.sv - directed self-checking bench for alu_operand_loader
module tb_alu_operand_loader;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   err_seen;

    alu_operand_loader_if #(.WIDTH(16), .BUS_W(8), .OPW(3)) bus ();

    alu_operand_loader #(.WIDTH(16), .BUS_W(8), .OPW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && bus.err_frame === 1'b1) err_seen++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic sof, input logic [7:0] d);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL beat_in_ready got=%b want=1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    task automatic check_out(input string name, input logic [2:0] op,
                             input logic [15:0] a, input logic [15:0] b);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_op !== op || bus.out_a !== a || bus.out_b !== b) begin
            failures++;
            $display("FAIL %s got v=%b op=%h a=%h b=%h want v=1 op=%h a=%h b=%h",
                     name, bus.out_valid, bus.out_op, bus.out_a, bus.out_b, op, a, b);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_op !== 3'd0 || bus.out_a !== 16'h0 ||
            bus.out_b !== 16'h0 || bus.err_frame !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state got v=%b op=%h a=%h b=%h err=%b rdy=%b want 0 0 0 0 0 1",
                     bus.out_valid, bus.out_op, bus.out_a, bus.out_b, bus.err_frame, bus.in_ready);
        end
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        beat(1'b1, 8'h03);
        beat(1'b0, 8'hAF);
        beat(1'b0, 8'h68);
        beat(1'b0, 8'h00);
        beat(1'b0, 8'h00);
        check_out("basic_issue", 3'd3, 16'h68AF, 16'h0000);
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_a !== 16'h68AF || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_one_cycle got v=%b a=%h rdy=%b want v=0 a=68af rdy=1",
                     bus.out_valid, bus.out_a, bus.in_ready);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        beat(1'b1, 8'h01);
        beat(1'b0, 8'hFF);
        beat(1'b0, 8'hFF);
        beat(1'b0, 8'h55);
        beat(1'b0, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            check_out("stall_hold", 3'd1, 16'hFFFF, 16'hFF55);
            checks++;
            if (bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_in_ready cycle=%0d got=%b want=0", i, bus.in_ready);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_abort();
        int e0;
        bus.out_ready = 1'b1;
        e0 = err_seen;
        beat(1'b1, 8'h02);
        beat(1'b0, 8'h11);
        checks++;
        if (bus.err_frame !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_early_err got=%b want=0", bus.err_frame);
        end
        beat(1'b1, 8'h05);
        checks++;
        if (bus.err_frame !== 1'b1) begin
            failures++;
            $display("FAIL abort_err_pulse got=%b want=1", bus.err_frame);
        end
        beat(1'b0, 8'h00);
        checks++;
        if (bus.err_frame !== 1'b0) begin
            failures++;
            $display("FAIL abort_err_width got=%b want=0", bus.err_frame);
        end
        beat(1'b0, 8'h00);
        beat(1'b0, 8'hCC);
        beat(1'b0, 8'hCC);
        check_out("abort_issue", 3'd5, 16'h0000, 16'hCCCC);
        tick();
        checks++;
        if (err_seen - e0 !== 1) begin
            failures++;
            $display("FAIL abort_err_count got=%0d want=1", err_seen - e0);
        end
    endtask

    task automatic test_idle_stray();
        int e0;
        e0 = err_seen;
        beat(1'b0, 8'h5A);
        checks++;
        if (bus.err_frame !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stray_err got err=%b v=%b want err=1 v=0", bus.err_frame, bus.out_valid);
        end
        tick();
        checks++;
        if (bus.err_frame !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stray_after got err=%b v=%b rdy=%b want 0 0 1",
                     bus.err_frame, bus.out_valid, bus.in_ready);
        end
        beat(1'b1, 8'h04);
        beat(1'b0, 8'h21);
        beat(1'b0, 8'h43);
        beat(1'b0, 8'h65);
        beat(1'b0, 8'h87);
        check_out("stray_then_frame", 3'd4, 16'h4321, 16'h8765);
        tick();
        checks++;
        if (err_seen - e0 !== 1) begin
            failures++;
            $display("FAIL stray_err_count got=%0d want=1", err_seen - e0);
        end
    endtask

    task automatic test_mid_reset();
        int e0;
        beat(1'b1, 8'h07);
        beat(1'b0, 8'h12);
        beat(1'b0, 8'h34);
        beat(1'b0, 8'h56);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_op !== 3'd0 || bus.out_a !== 16'h0 ||
            bus.out_b !== 16'h0 || bus.err_frame !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_state got v=%b op=%h a=%h b=%h err=%b rdy=%b want 0 0 0 0 0 1",
                     bus.out_valid, bus.out_op, bus.out_a, bus.out_b, bus.err_frame, bus.in_ready);
        end
        e0 = err_seen;
        beat(1'b1, 8'h06);
        beat(1'b0, 8'h9A);
        beat(1'b0, 8'hBC);
        beat(1'b0, 8'hDE);
        beat(1'b0, 8'hF0);
        check_out("midreset_frame", 3'd6, 16'hBC9A, 16'hF0DE);
        tick();
        checks++;
        if (err_seen - e0 !== 0) begin
            failures++;
            $display("FAIL midreset_err_count got=%0d want=0", err_seen - e0);
        end
    endtask

    task automatic test_gapped();
        int e0;
        logic [7:0] bytes [5];
        bytes = '{8'h01, 8'hFF, 8'hFF, 8'h55, 8'hFF};
        bus.out_ready = 1'b1;
        e0 = err_seen;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) tick();
            beat(i == 0, bytes[i]);
        end
        check_out("gapped_issue", 3'd1, 16'hFFFF, 16'hFF55);
        tick();
        checks++;
        if (err_seen - e0 !== 0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL gapped_tail got errs=%0d v=%b want errs=0 v=0", err_seen - e0, bus.out_valid);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        err_seen      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_abort();
        test_idle_stray();
        test_mid_reset();
        test_gapped();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
